// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life engine: default board geometry,
// rule thresholds and the row-major / toroidal cell-index helpers.
package life_pkg;

    localparam int DEF_GRID_W = 8;
    localparam int DEF_GRID_H = 8;
    localparam int DEF_GEN_W  = 16;

    localparam int NBR_CNT = 8;

    localparam logic [3:0] BIRTH_CNT   = 4'd3;
    localparam logic [3:0] SURVIVE_CNT = 4'd2;

    function automatic int cell_index(input int row, input int col, input int w);
        return row * w + col;
    endfunction

    function automatic int cell_row(input int idx, input int w);
        return idx / w;
    endfunction

    function automatic int cell_col(input int idx, input int w);
        return idx % w;
    endfunction

    function automatic int wrap_inc(input int v, input int m);
        return (v == m - 1) ? 0 : v + 1;
    endfunction

    function automatic int wrap_dec(input int v, input int m);
        return (v == 0) ? m - 1 : v - 1;
    endfunction

    // Neighbour k (0..7) walks the 3x3 window row by row, skipping the centre.
    function automatic int neighbour_index(input int idx, input int k,
                                           input int w, input int h);
        int p;
        int r;
        int c;
        p = (k < 4) ? k : k + 1;
        r = cell_row(idx, w);
        c = cell_col(idx, w);
        case (p / 3)
            0:       r = wrap_dec(r, h);
            2:       r = wrap_inc(r, h);
            default: r = r;
        endcase
        case (p % 3)
            0:       c = wrap_dec(c, w);
            2:       c = wrap_inc(c, w);
            default: c = c;
        endcase
        return cell_index(r, c, w);
    endfunction

endpackage

// File: rtl/life_neighbour_rule.sv
// Combinational Life rule: counts the eight neighbour bits and applies
// birth / survival to the centre cell.
module life_neighbour_rule
    import life_pkg::*;
(
    input  logic [NBR_CNT-1:0] nbr_i,
    input  logic               centre_i,
    output logic [3:0]         count_o,
    output logic               next_o
);

    always_comb begin
        count_o = 4'd0;
        for (int i = 0; i < NBR_CNT; i++) begin
            count_o = count_o + 4'(nbr_i[i]);
        end
    end

    assign next_o = (count_o == BIRTH_CNT) | (centre_i & (count_o == SURVIVE_CNT));

endmodule

// File: rtl/life_cell_datapath.sv
// Cell-evaluation datapath: holds the current board, evaluates one cell per
// READ/WRITE/WAIT sequence with toroidal wrap and commits a full generation.
module life_cell_datapath
    import life_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int GEN_W  = DEF_GEN_W,
    localparam int N     = GRID_W * GRID_H,
    localparam int AW    = $clog2(N)
) (
    input  logic             clk_50MHz_i,
    input  logic             rst_async_la_i,
    input  logic             ss_we_i,
    input  logic             ss_rst_i,
    input  logic             ram_we_i,
    input  logic             subtract_addr_i,
    input  logic             addr_count_en_i,
    input  logic             load_i,
    input  logic [N-1:0]     load_board_i,
    output logic             count_done_o,
    output logic [AW-1:0]    cell_addr_o,
    output logic             next_cell_o,
    output logic [N-1:0]     board_o,
    output logic [GEN_W-1:0] gen_count_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    logic [N-1:0]     cur_q,    cur_d;
    logic [N-1:0]     nxt_q,    nxt_d;
    logic             result_q, result_d;
    logic [AW-1:0]    addr_q,   addr_d;
    logic [GEN_W-1:0] gen_q,    gen_d;

    logic [AW-1:0]      nbr_idx [NBR_CNT];
    logic [NBR_CNT-1:0] nbr_bits;
    logic [3:0]         nbr_count_unused;
    logic               rule_next;
    logic               last_cell;
    logic               write_en;

    // Wrapped neighbour addresses are pure functions of the current address.
    generate
        for (genvar gi = 0; gi < NBR_CNT; gi++) begin : g_nbr
            assign nbr_idx[gi]  = AW'(neighbour_index(int'(addr_q), gi, GRID_W, GRID_H));
            assign nbr_bits[gi] = cur_q[nbr_idx[gi]];
        end
    endgenerate

    life_neighbour_rule u_rule (
        .nbr_i    (nbr_bits),
        .centre_i (cur_q[addr_q]),
        .count_o  (nbr_count_unused),
        .next_o   (rule_next)
    );

    assign last_cell = (addr_q == LAST_ADDR);
    assign write_en  = ram_we_i & subtract_addr_i;

    always_comb begin
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        result_d = result_q;
        addr_d   = addr_q;
        gen_d    = gen_q;

        if (load_i) begin
            cur_d    = load_board_i;
            nxt_d    = load_board_i;
            result_d = 1'b0;
            addr_d   = '0;
            gen_d    = '0;
        end else begin
            if (!ss_rst_i) begin
                result_d = 1'b0;
            end else if (ss_we_i) begin
                result_d = rule_next;
            end

            if (write_en) begin
                nxt_d[addr_q] = result_q;
            end

            // nxt_d already carries the last result, so it is the whole new board.
            if (write_en && last_cell) begin
                cur_d  = nxt_d;
                addr_d = '0;
                gen_d  = gen_q + GEN_W'(1);
            end else if (addr_count_en_i) begin
                addr_d = last_cell ? '0 : addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            cur_q    <= '0;
            nxt_q    <= '0;
            result_q <= 1'b0;
            addr_q   <= '0;
            gen_q    <= '0;
        end else begin
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            gen_q    <= gen_d;
        end
    end

    assign count_done_o = last_cell;
    assign cell_addr_o  = addr_q;
    assign next_cell_o  = result_q;
    assign board_o      = cur_q;
    assign gen_count_o  = gen_q;

endmodule

// File: doc/life_cell_datapath.md
# life_cell_datapath

Cell-evaluation datapath for the Game of Life engine. It sits directly downstream of the life control FSM and is driven by that FSM's strobes. It holds the current board, evaluates one cell per READ/WRITE/WAIT cycle using toroidal wrap, and buffers the results in a next-generation bank. When the last cell is written it commits the whole generation and reports completion back to the FSM through `count_done_o`.

## Interface
- GRID_W, 8, board columns (≥3)
- GRID_H, 8, board rows (≥3)
- GEN_W, 16, generation counter width
- Derived: N = GRID_W*GRID_H; AW = $clog2(N); cell index = row*GRID_W + col, row-major
- clk_50MHz_i  in  1  system clock, rising edge
- rst_async_la_i  in  1  asynchronous, active-low reset
- ss_we_i  in  1  latch the evaluated next state of the cell at `cell_addr_o` into the result register
- ss_rst_i  in  1  active-low synchronous clear of the result register
- ram_we_i  in  1  write the result register into the next bank
- subtract_addr_i  in  1  write qualifier; `ram_we_i` takes effect only when this is 1
- addr_count_en_i  in  1  advance the cell address
- load_i  in  1  seed the board (synchronous)
- load_board_i  in  N  seed pattern
- count_done_o  out  1  combinational; `cell_addr_o == N-1`
- cell_addr_o  out  AW  current cell address
- next_cell_o  out  1  result register
- board_o  out  N  current-generation bank
- gen_count_o  out  GEN_W  committed generations

## Operation
- Reset values: cur, nxt, result, addr and gen all 0. Therefore `count_done_o` is 0, except when N=1, which is not permitted.
- Neighbour count: sum of the 8 neighbours of the cell at addr in cur, over 4 bits (0..8).
  - Neighbour column = (col±1) mod GRID_W; neighbour row = (row±1) mod GRID_H.
- Rule: next = (count==3) | (cur[addr] & count==2).
- Result register:
  - `ss_rst_i`=0 clears it; this has priority over `ss_we_i`.
  - Otherwise `ss_we_i`=1 loads the rule output.
- Write: when `ram_we_i` & `subtract_addr_i`, nxt[addr] <= result.
  - If `ram_we_i` is high while `subtract_addr_i` is low, no write occurs.
- Commit: the qualified write with `count_done_o`=1 also does all of the following on the same edge:
  - cur <= nxt, with bit N-1 replaced by the result;
  - addr <= 0;
  - gen <= gen+1, wrapping modulo 2^GEN_W.
- Address: `addr_count_en_i` increments addr. At N-1 it wraps to 0; no commit happens on wrap.
  - If an increment and a commit fall on the same edge, the commit wins and addr becomes 0.
- Load: `load_i` has priority over every other input.
  - cur <= load_board_i and nxt <= load_board_i.
  - addr, result and gen are set to 0.
- cur never changes except on commit, load or reset. This means every evaluation within one generation sees the same board.

## Timing
- One cell takes three clocks: READ (`ss_we_i`) → WRITE (`ram_we_i`, `subtract_addr_i`) → WAIT (`addr_count_en_i`).
  - The result is valid on `next_cell_o` one edge after `ss_we_i`.
  - nxt is updated on the WRITE edge.
  - addr is updated on the WAIT edge.
- Full generation: 3N-1 clocks from the first READ to the commit edge.
  - The last cell skips WAIT; the FSM returns to IDLE.
- `count_done_o` is combinational from addr, so the FSM sees it in WRITE of cell N-1 with no added latency.
- `board_o` and `gen_count_o` update on the commit edge.
- Reset mid-generation: everything returns to the reset values immediately. The partial nxt is discarded.
- Load mid-generation: the partial generation is discarded; the next READ evaluates cell 0 of the loaded board.

## Structure
- Shared package `life_pkg`:
  - default GRID_W/GRID_H/GEN_W;
  - rule constants BIRTH_CNT=3 and SURVIVE_CNT=2;
  - the cell-index/row/col helper functions.
- One combinational sub-module, `life_neighbour_rule`.
  - Inputs: the 8 neighbour bits and the centre bit.
  - Outputs: the 4-bit count and the next state.
- Wrap-address generation, the result register, both banks, the address counter and the generation counter stay in the top level.

## Test plan
- Blinker, 8×8: load bits {26,27,28}, run one generation (3·64-1 = 191 clocks of FSM strobes) → board_o = {19,27,35}, gen_count_o=1. A second generation → {26,27,28}, gen=2.
- Toroidal wrap: load bits {0,7,56,63} (a corner block joined through wrap) → after one generation the board is unchanged and gen=1.
- Isolated cell: load bit 27 only → board_o=0 after commit. During the generation `next_cell_o` is 0 for every cell and cur stays equal to the loaded pattern until the commit edge.
- Address wrap and write qualifier:
  - 63 `addr_count_en_i` pulses → `count_done_o`=1 and cell_addr=63. A 64th pulse → addr=0, `count_done_o`=0, gen unchanged.
  - `ram_we_i` with `subtract_addr_i`=0 → nxt unchanged.
- Priorities: `ss_we_i` together with `ss_rst_i`=0 → result 0. A commit on the same edge as `addr_count_en_i` → addr=0.
- Load mid-run and reset mid-run:
  - Start the blinker, assert `load_i` with {0} at cell 30 → board={0}, addr=0, gen=0.
  - Drop `rst_async_la_i` between clock edges → all outputs 0 immediately.
